comparator_offset_cal: RTL and testbench

- Clocked calibration controller for a bank of NCH continuous-time comparators.
- Each comparator has 5-bit-style cfg_offset_p / cfg_offset_n trim inputs. CFG_W generalises the trim width; the n-side bus is bit-reversed.
- While calibration runs, the block shorts the comparator inputs (cal_en) and trims all channels in parallel with a signed successive-approximation search and majority-vote sampling.
- It drives the comparators' trim buses directly and signals completion and per-channel saturation to the top-level sequencer.

---
 rtl/comparator_offset_cal.sv | 169 ++++++++++++++++
 tb/tb_comparator_offset_cal.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/comparator_offset_cal.sv
// Offset calibration controller for a bank of comparators: parallel signed SAR trim
// search with majority-vote sampling. Drives the p/n trim buses and reports rail hits.
module comparator_offset_cal #(
  parameter int NCH    = 4,
  parameter int CFG_W  = 5,
  parameter int NAVG   = 8,
  parameter int SETTLE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NCH-1:0]       cmp_out,
  output logic                 cal_en,
  output logic [NCH*CFG_W-1:0] cfg_offset_p,
  output logic [NCH*CFG_W-1:0] cfg_offset_n,
  output logic                 busy,
  output logic                 done,
  output logic [NCH-1:0]       cal_fail
);

  localparam int CNT_W = $clog2(NAVG + 1);
  localparam int K_W   = $clog2(CFG_W + 1);
  localparam int TMR_W = $clog2(((SETTLE > NAVG) ? SETTLE : NAVG) + 1);
  localparam logic [CFG_W:0] MID = {1'b1, {CFG_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    SETTLING,
    SAMPLE,
    DECIDE,
    FINISH
  } state_t;

  state_t           state_reg, state_next;
  logic [K_W-1:0]   k_reg, k_next;
  logic [TMR_W-1:0] tmr_reg, tmr_next;
  logic             init_run, sample_en, decide_en, fin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      tmr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      tmr_reg   <= tmr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    tmr_next   = tmr_reg;
    init_run   = 1'b0;
    sample_en  = 1'b0;
    decide_en  = 1'b0;
    fin        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SETTLING;
          k_next     = K_W'(CFG_W);
          tmr_next   = '0;
          init_run   = 1'b1;
        end
      end
      SETTLING: begin
        if (tmr_reg == TMR_W'(SETTLE - 1)) begin
          tmr_next   = '0;
          state_next = SAMPLE;
        end else begin
          tmr_next = tmr_reg + TMR_W'(1);
        end
      end
      SAMPLE: begin
        sample_en = 1'b1;
        if (tmr_reg == TMR_W'(NAVG - 1)) begin
          tmr_next   = '0;
          state_next = DECIDE;
        end else begin
          tmr_next = tmr_reg + TMR_W'(1);
        end
      end
      DECIDE: begin
        decide_en = 1'b1;
        if (k_reg == '0) begin
          state_next = FINISH;
        end else begin
          k_next     = k_reg - K_W'(1);
          state_next = SETTLING;
        end
      end
      FINISH: begin
        fin        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy   = (state_reg == SETTLING) || (state_reg == SAMPLE) || (state_reg == DECIDE);
  assign cal_en = busy;
  assign done   = (state_reg == FINISH);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CFG_W:0]   u_reg, u_next;
      logic [CNT_W-1:0] ones_reg, ones_next;
      logic             fail_reg, fail_next;
      logic [CFG_W-1:0] neg_mag, p_fld, n_fld;
      logic             at_rail;

      // Mid-scale reset value keeps both trim fields at zero.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          u_reg    <= MID;
          ones_reg <= '0;
          fail_reg <= 1'b0;
        end else begin
          u_reg    <= u_next;
          ones_reg <= ones_next;
          fail_reg <= fail_next;
        end
      end

      always_comb begin
        u_next    = u_reg;
        ones_next = ones_reg;
        fail_next = fail_reg;
        if (init_run) begin
          u_next    = MID;
          ones_next = '0;
          fail_next = 1'b0;
        end else if (sample_en) begin
          if (cmp_out[gi]) ones_next = ones_reg + CNT_W'(1);
        end else if (decide_en) begin
          // Strict majority of ones means net offset still positive: drop the trial bit.
          if (ones_reg > CNT_W'(NAVG / 2)) u_next[k_reg] = 1'b0;
          if (k_reg != '0) u_next[k_reg - K_W'(1)] = 1'b1;
          ones_next = '0;
        end else if (fin) begin
          fail_next = at_rail;
        end
      end

      // u = 0 would be -2^CFG_W; it saturates to the -(2^CFG_W-1) rail.
      assign neg_mag = (u_reg[CFG_W-1:0] == '0) ? {CFG_W{1'b1}}
                                                : (CFG_W'(0) - u_reg[CFG_W-1:0]);
      assign at_rail = u_reg[CFG_W] ? (&u_reg[CFG_W-1:0]) : (u_reg[CFG_W-1:1] == '0);

      always_comb begin
        p_fld = '0;
        n_fld = '0;
        if (u_reg[CFG_W]) begin
          p_fld = u_reg[CFG_W-1:0];
        end else begin
          for (int b = 0; b < CFG_W; b++) n_fld[b] = neg_mag[CFG_W-1-b];
        end
      end

      assign cfg_offset_p[gi*CFG_W +: CFG_W] = p_fld;
      assign cfg_offset_n[gi*CFG_W +: CFG_W] = n_fld;
      assign cal_fail[gi]                    = fail_reg;
    end
  endgenerate

endmodule

// File: tb/tb_comparator_offset_cal.sv
// Directed bench for comparator_offset_cal: behavioural comparators (1 LSB per mV,
// offsets quantised to whole LSBs) driven from the live trim buses.
module tb_comparator_offset_cal;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  cmp_out;
  logic        cal_en, busy, done;
  logic [19:0] cfg_offset_p, cfg_offset_n;
  logic [3:0]  cal_fail;

  int n_cmp = 0;
  int n_mis = 0;
  int off  [4];
  int mode [4];   // 0 clean, 1 three flips per window, 2 exact 4-of-8 tie

  comparator_offset_cal #(.NCH(4), .CFG_W(5), .NAVG(8), .SETTLE(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cmp_out      (cmp_out),
    .cal_en       (cal_en),
    .cfg_offset_p (cfg_offset_p),
    .cfg_offset_n (cfg_offset_n),
    .busy         (busy),
    .done         (done),
    .cal_fail     (cal_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Signed trim seen by channel ch: p field minus bit-reversed n field.
  function automatic int trim_of(input int ch);
    logic [4:0] pf, nf, mag;
    pf = cfg_offset_p[ch*5 +: 5];
    nf = cfg_offset_n[ch*5 +: 5];
    for (int b = 0; b < 5; b++) mag[b] = nf[4-b];
    return int'(pf) - int'(mag);
  endfunction

  // Cycle n after start: 13-cycle bit period, samples at period offsets 4..11.
  function automatic logic [3:0] model_cmp(input int n);
    int p, j;
    logic [3:0] r;
    p = (n - 1) % 13;
    j = p - 4;
    for (int c = 0; c < 4; c++) begin
      r[c] = (off[c] + trim_of(c)) > 0;
      if (mode[c] == 1 && (j == 1 || j == 4 || j == 6)) r[c] = ~r[c];
      if (mode[c] == 2) r[c] = (j >= 0 && j < 4);
    end
    return r;
  endfunction

  task automatic run_cal(input string name, input int abort_at, input bit protocol,
                         output int done_cyc, output int done_cnt, output int bad_cyc);
    done_cyc = 0;
    done_cnt = 0;
    bad_cyc  = 0;
    @(negedge clk);
    start   = 1'b1;
    cmp_out = model_cmp(0);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 85; n++) begin
      cmp_out = model_cmp(n);
      start   = protocol && (n == 30 || n == 79);
      if (abort_at != 0 && n == abort_at) begin
        $display("run %s: stopped at cycle %0d for reset", name, n);
        return;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (busy !== (n <= 78) || cal_en !== (n <= 78) || done !== (n == 79)) bad_cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    $display("run %s: done at cycle %0d, pulses %0d, p=0x%05h n=0x%05h cal_fail=%b",
             name, done_cyc, done_cnt, cfg_offset_p, cfg_offset_n, cal_fail);
  endtask

  initial begin
    int dc, dn, bad, rst_done;
    rst = 1'b1; start = 1'b0; cmp_out = '0;
    repeat (3) @(negedge clk);
    chk("reset_cal_en", 32'(cal_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_cal_fail", 32'(cal_fail), 32'd0);
    chk("reset_p", 32'(cfg_offset_p), 32'd0);
    chk("reset_n", 32'(cfg_offset_n), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Run A: +7, +40 (saturates), -12, 0 LSB; start pulsed mid-run and held in done cycle.
    off = '{7, 40, -12, 0};
    mode = '{0, 0, 0, 0};
    run_cal("A", 0, 1'b1, dc, dn, bad);
    chk("A_done_cycle", 32'(dc), 32'd79);
    chk("A_done_count", 32'(dn), 32'd1);
    chk("A_busy_cal_en_done_timing", 32'(bad), 32'd0);
    chk("A_p", 32'(cfg_offset_p), 32'h03000);
    chk("A_n", 32'(cfg_offset_n), 32'h003FC);
    chk("A_cal_fail", 32'(cal_fail), 32'b0010);
    chk("A_idle_busy", 32'(busy), 32'd0);

    // Run B: reset during SAMPLE of bit 3 (cycle 33).
    run_cal("B", 33, 1'b0, dc, dn, bad);
    chk("B_mid_p", 32'(cfg_offset_p), 32'h42000);
    chk("B_mid_n", 32'(cfg_offset_n), 32'h00062);
    chk("B_mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("B_rst_cal_en", 32'(cal_en), 32'd0);
    chk("B_rst_busy", 32'(busy), 32'd0);
    chk("B_rst_cal_fail", 32'(cal_fail), 32'd0);
    chk("B_rst_p", 32'(cfg_offset_p), 32'd0);
    chk("B_rst_n", 32'(cfg_offset_n), 32'd0);
    rst_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) rst_done++;
    end
    chk("B_no_done_pulse", 32'(rst_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Run C: noisy +5 on ch0, 0 on ch1, -3 on ch2, permanent 4/4 tie on ch3.
    off = '{5, 0, -3, 0};
    mode = '{1, 0, 0, 2};
    run_cal("C", 0, 1'b0, dc, dn, bad);
    chk("C_done_cycle", 32'(dc), 32'd79);
    chk("C_done_count", 32'(dn), 32'd1);
    chk("C_busy_cal_en_done_timing", 32'(bad), 32'd0);
    chk("C_p", 32'(cfg_offset_p), 32'hF8C00);
    chk("C_n", 32'(cfg_offset_n), 32'h00014);
    chk("C_cal_fail", 32'(cal_fail), 32'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
